// File: rtl/id_decode_pkg.sv
// Shared constants for the MIPS decode stage: opcodes, ALU operation codes and
// the per-instruction control bundle carried into the ID/EX register.
package id_decode_pkg;

    localparam int REG_W = 5;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'h0,
        ALU_SUB   = 4'h1,
        ALU_AND   = 4'h2,
        ALU_OR    = 4'h3,
        ALU_SLT   = 4'h4,
        ALU_LUI   = 4'h5,
        ALU_FUNCT = 4'hF
    } alu_op_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '{alu_op: ALU_ADD, default: 1'b0};

endpackage

// File: rtl/id_decode_regfile.sv
// 32x32 register file, two combinational read ports, one write port.
// REGFILE_BYPASS_EN: a same-cycle write to the read register returns W_data.
module regfile
    import id_decode_pkg::*;
#(
    parameter int WORD = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] ra1,
    input  logic [REG_W-1:0] ra2,
    output logic [WORD-1:0]  rd1,
    output logic [WORD-1:0]  rd2,
    input  logic             we,
    input  logic [REG_W-1:0] wa,
    input  logic [WORD-1:0]  wd
);

    logic [WORD-1:0] regs [32];

    // NOTE: the whole array is cleared on reset because software relies on
    // registers reading 0 after reset; this forces flops rather than a RAM macro.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && wa != '0) begin
            regs[wa] <= wd;
        end
    end

    function automatic logic [WORD-1:0] read_port(input logic [REG_W-1:0] a);
        if (a == '0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (we && wa == a) return wd;
`endif
        return regs[a];
    endfunction

    always_comb begin
        rd1 = read_port(ra1);
        rd2 = read_port(ra2);
    end

endmodule

// File: rtl/id_decode.sv
// MIPS decode stage: instruction decode, hazard stall, branch/jump resolution
// and the ID/EX register. Build option REGFILE_BYPASS_EN selects regfile bypass.
module id_decode
    import id_decode_pkg::*;
#(
    parameter int WORD = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WORD-1:0]  nPC,
    input  logic [WORD-1:0]  IR,
    input  logic             EX_RegWrite,
    input  logic             EX_MemRead,
    input  logic [REG_W-1:0] EX_wreg,
    input  logic             MEM_MemRead,
    input  logic [REG_W-1:0] MEM_wreg,
    input  logic             W_RegWrite,
    input  logic [REG_W-1:0] W_wreg,
    input  logic [WORD-1:0]  W_data,
    output logic             PCSrc,
    output logic [WORD-1:0]  BrDest,
    output logic             Stall,
    output logic [WORD-1:0]  D_nPC,
    output logic [WORD-1:0]  D_A,
    output logic [WORD-1:0]  D_B,
    output logic [WORD-1:0]  D_Imm,
    output logic [REG_W-1:0] D_wreg,
    output logic [3:0]       D_ALUOp,
    output logic             D_ALUSrc,
    output logic             D_RegWrite,
    output logic             D_MemRead,
    output logic             D_MemWrite,
    output logic             D_MemToReg,
    output logic             D_Illegal
);

    logic [5:0]       op;
    logic [REG_W-1:0] rs, rt, rd;
    logic [15:0]      imm16;
    logic [WORD-1:0]  rdata_a, rdata_b;
    logic [WORD-1:0]  imm_sext;
    logic             unused_fields;

    assign op    = IR[31:26];
    assign rs    = IR[25:21];
    assign rt    = IR[20:16];
    assign rd    = IR[15:11];
    assign imm16 = IR[15:0];
    assign imm_sext = {{(WORD-16){imm16[15]}}, imm16};
    // shamt/funct are consumed by execute through ALU_FUNCT, not here
    assign unused_fields = ^IR[10:0];

    regfile #(.WORD(WORD)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rdata_a),
        .rd2   (rdata_b),
        .we    (W_RegWrite),
        .wa    (W_wreg),
        .wd    (W_data)
    );

    ctrl_t            ctrl;
    logic [REG_W-1:0] dec_wreg;
    logic [WORD-1:0]  dec_imm;
    logic             uses_rs, uses_rt, is_branch, is_jump;

    // NOTE: every always_comb output gets a default first so no path leaves
    // a variable unassigned, which would infer a latch.
    always_comb begin
        ctrl      = CTRL_BUBBLE;
        dec_wreg  = '0;
        dec_imm   = imm_sext;
        uses_rs   = 1'b1;
        uses_rt   = 1'b0;
        is_branch = 1'b0;
        is_jump   = 1'b0;
        unique case (op)
            OP_RTYPE: begin
                ctrl.alu_op = ALU_FUNCT; ctrl.reg_write = 1'b1;
                dec_wreg = rd; uses_rt = 1'b1;
            end
            OP_LW: begin
                ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1;
                ctrl.mem_read = 1'b1; ctrl.mem_to_reg = 1'b1;
                dec_wreg = rt;
            end
            OP_SW: begin
                ctrl.alu_src = 1'b1; ctrl.mem_write = 1'b1; uses_rt = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl.alu_op = ALU_SUB; uses_rt = 1'b1; is_branch = 1'b1;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LUI: begin
                ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; dec_wreg = rt;
                case (op)
                    OP_SLTI: ctrl.alu_op = ALU_SLT;
                    OP_ANDI: ctrl.alu_op = ALU_AND;
                    OP_ORI:  ctrl.alu_op = ALU_OR;
                    OP_LUI:  ctrl.alu_op = ALU_LUI;
                    default: ctrl.alu_op = ALU_ADD;
                endcase
                if (op == OP_ANDI || op == OP_ORI) dec_imm = {{(WORD-16){1'b0}}, imm16};
                if (op == OP_LUI) uses_rs = 1'b0;
            end
            OP_J: begin
                uses_rs = 1'b0; is_jump = 1'b1;
            end
            default: ctrl.illegal = 1'b1;
        endcase
    end

    function automatic logic src_hit(input logic [REG_W-1:0] w, input logic use_a,
                                     input logic use_b, input logic [REG_W-1:0] a,
                                     input logic [REG_W-1:0] b);
        return (use_a && a != '0 && a == w) || (use_b && b != '0 && b == w);
    endfunction

    logic ex_hit, mem_hit, br_taken;

    always_comb begin
        ex_hit  = src_hit(EX_wreg, uses_rs, uses_rt, rs, rt);
        mem_hit = src_hit(MEM_wreg, uses_rs, uses_rt, rs, rt);
        Stall   = (EX_MemRead && ex_hit)
                || (is_branch && EX_RegWrite && ex_hit)
                || (is_branch && MEM_MemRead && mem_hit);
        br_taken = is_branch && ((rdata_a == rdata_b) == (op == OP_BEQ));
        PCSrc    = !Stall && (br_taken || is_jump);
        BrDest   = is_jump ? {nPC[WORD-1:28], IR[25:0], 2'b00}
                           : nPC + (imm_sext << 2);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset || Stall) begin
            D_nPC <= '0; D_A <= '0; D_B <= '0; D_Imm <= '0; D_wreg <= '0;
            D_ALUOp <= '0; D_ALUSrc <= 1'b0; D_RegWrite <= 1'b0;
            D_MemRead <= 1'b0; D_MemWrite <= 1'b0; D_MemToReg <= 1'b0;
            D_Illegal <= 1'b0;
        end else begin
            D_nPC      <= nPC;
            D_A        <= rdata_a;
            D_B        <= rdata_b;
            D_Imm      <= dec_imm;
            D_wreg     <= dec_wreg;
            D_ALUOp    <= ctrl.alu_op;
            D_ALUSrc   <= ctrl.alu_src;
            D_RegWrite <= ctrl.reg_write;
            D_MemRead  <= ctrl.mem_read;
            D_MemWrite <= ctrl.mem_write;
            D_MemToReg <= ctrl.mem_to_reg;
            D_Illegal  <= ctrl.illegal;
        end
    end

endmodule
